// File: rtl/izigzag_stream_demux_param.sv
// Inverse-zigzag stream distributor: deals tokens in bursts round-robin across NCH channels,
// realigning to channel 0 at every BLOCK boundary. Optional end-of-block flag: IZZ_EOB_FLAG_EN.
module izigzag_stream_demux_param #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int BURST = 2,
    parameter int BLOCK = 64,
    localparam int IDXW = $clog2(BLOCK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_in_d,
    input  logic             i_in_v,
    output logic             o_in_r,
    output logic [WIDTH-1:0] o_out_d,
    output logic [NCH-1:0]   o_out_v,
    input  logic [NCH-1:0]   i_out_r,
`ifdef IZZ_EOB_FLAG_EN
    output logic             o_eob,
`endif
    output logic [IDXW-1:0]  o_blk_idx
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;

    logic [WIDTH-1:0] r_data;
    logic [CHW-1:0]   r_dest;
    logic             r_full;
    logic [CHW-1:0]   r_ch;
    logic [BCW-1:0]   r_burst;
    logic [IDXW-1:0]  r_index;

    logic w_dest_rdy;
    logic w_pop;
    logic w_acc;
    logic w_last;

    // Only the destination channel's ready can drain the holding register.
    always_comb begin
        w_dest_rdy = 1'b0;
        o_out_v    = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_dest == CHW'(k)) begin
                w_dest_rdy = i_out_r[k];
                o_out_v[k] = r_full;
            end
        end
    end

    assign w_pop     = r_full && w_dest_rdy;
    assign o_in_r    = !r_full || w_pop;
    assign w_acc     = i_in_v && o_in_r;
    assign w_last    = (r_index == IDXW'(BLOCK - 1));
    assign o_out_d   = r_data;
    assign o_blk_idx = r_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_dest <= '0;
            r_full <= 1'b0;
        end else if (w_acc) begin
            r_data <= i_in_d;
            r_dest <= r_ch;
            r_full <= 1'b1;
        end else if (w_pop) begin
            r_full <= 1'b0;
        end
    end

    // Block boundary takes priority over burst/channel wrap so every block starts on channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index <= '0;
            r_ch    <= '0;
            r_burst <= '0;
        end else if (w_acc) begin
            if (w_last) begin
                r_index <= '0;
                r_ch    <= '0;
                r_burst <= '0;
            end else begin
                r_index <= r_index + 1'b1;
                if (r_burst == BCW'(BURST - 1)) begin
                    r_burst <= '0;
                    r_ch    <= (r_ch == CHW'(NCH - 1)) ? '0 : r_ch + 1'b1;
                end else begin
                    r_burst <= r_burst + 1'b1;
                end
            end
        end
    end

`ifdef IZZ_EOB_FLAG_EN
    logic r_eob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eob <= 1'b0;
        end else if (w_acc) begin
            r_eob <= w_last;
        end else if (w_pop) begin
            r_eob <= 1'b0;
        end
    end

    assign o_eob = r_eob;
`endif

endmodule

// File: tb/tb_izigzag_stream_demux_param.sv
// Directed bench for izigzag_stream_demux_param (default and NCH=4/BURST=3/BLOCK=10 instances).
// Build with IZZ_EOB_FLAG_EN defined to also exercise the end-of-block flag.
module tb_izigzag_stream_demux_param;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_d;
    logic        in_v;
    logic        in_r;
    logic [15:0] out_d;
    logic [7:0]  out_v;
    logic [7:0]  out_r;
    logic [6:0]  blk_idx;
`ifdef IZZ_EOB_FLAG_EN
    logic        eob;
`endif

    logic [15:0] d2_in_d;
    logic        d2_in_v;
    logic        d2_in_r;
    logic [15:0] d2_out_d;
    logic [3:0]  d2_out_v;
    logic [3:0]  d2_out_r;
    logic [3:0]  d2_blk_idx;
`ifdef IZZ_EOB_FLAG_EN
    logic        d2_eob;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    izigzag_stream_demux_param dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_d(in_d), .i_in_v(in_v), .o_in_r(in_r),
        .o_out_d(out_d), .o_out_v(out_v), .i_out_r(out_r),
`ifdef IZZ_EOB_FLAG_EN
        .o_eob(eob),
`endif
        .o_blk_idx(blk_idx)
    );

    izigzag_stream_demux_param #(.WIDTH(16), .NCH(4), .BURST(3), .BLOCK(10)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_in_d(d2_in_d), .i_in_v(d2_in_v), .o_in_r(d2_in_r),
        .o_out_d(d2_out_d), .o_out_v(d2_out_v), .i_out_r(d2_out_r),
`ifdef IZZ_EOB_FLAG_EN
        .o_eob(d2_eob),
`endif
        .o_blk_idx(d2_blk_idx)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        in_v = 1'b0; in_d = '0; out_r = 8'hFF;
        d2_in_v = 1'b0; d2_in_d = '0; d2_out_r = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_v = 1'b1; in_d = 16'h1234; out_r = 8'hFF;
        d2_in_v = 1'b0; d2_in_d = '0; d2_out_r = 4'hF;
        @(negedge clk);
        tests++; if (out_v !== 8'h00) begin fails++; $display("FAIL reset_out_v got=%h exp=00", out_v); end
        tests++; if (out_d !== 16'h0) begin fails++; $display("FAIL reset_out_d got=%h exp=0000", out_d); end
        tests++; if (blk_idx !== 7'd0) begin fails++; $display("FAIL reset_blk_idx got=%0d exp=0", blk_idx); end
        tests++; if (in_r !== 1'b1) begin fails++; $display("FAIL reset_in_r got=%b exp=1", in_r); end
        tests++; if (d2_out_v !== 4'h0) begin fails++; $display("FAIL reset_d2_out_v got=%h exp=0", d2_out_v); end
`ifdef IZZ_EOB_FLAG_EN
        tests++; if (eob !== 1'b0) begin fails++; $display("FAIL reset_eob got=%b exp=0", eob); end
`endif
        in_v = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [7:0] exp_v;
        do_reset();
        for (int k = 0; k <= 64; k++) begin
            @(negedge clk);
            if (k > 0) begin
                exp_v = 8'd1 << (((k - 1) / 2) % 8);
                tests++; if (out_d !== 16'(k - 1)) begin fails++; $display("FAIL stream_out_d k=%0d got=%0d exp=%0d", k - 1, out_d, k - 1); end
                tests++; if (out_v !== exp_v) begin fails++; $display("FAIL stream_out_v k=%0d got=%h exp=%h", k - 1, out_v, exp_v); end
            end
            tests++; if (in_r !== 1'b1) begin fails++; $display("FAIL stream_in_r k=%0d got=%b exp=1", k, in_r); end
            tests++; if (blk_idx !== 7'(k % 64)) begin fails++; $display("FAIL stream_blk_idx k=%0d got=%0d exp=%0d", k, blk_idx, k % 64); end
            if (k < 64) begin in_d = 16'(k); in_v = 1'b1; end
            else in_v = 1'b0;
        end
        @(negedge clk);
        tests++; if (out_v !== 8'h00) begin fails++; $display("FAIL stream_drain got=%h exp=00", out_v); end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        out_r = 8'h00; in_d = 16'd0; in_v = 1'b1;
        @(negedge clk);
        in_d = 16'd1;
        for (int c = 0; c < 2; c++) begin
            tests++; if (out_v !== 8'h01) begin fails++; $display("FAIL bp_out_v c=%0d got=%h exp=01", c, out_v); end
            tests++; if (out_d !== 16'd0) begin fails++; $display("FAIL bp_out_d c=%0d got=%0d exp=0", c, out_d); end
            tests++; if (in_r !== 1'b0) begin fails++; $display("FAIL bp_in_r c=%0d got=%b exp=0", c, in_r); end
            tests++; if (blk_idx !== 7'd1) begin fails++; $display("FAIL bp_blk_idx c=%0d got=%0d exp=1", c, blk_idx); end
            if (c == 0) @(negedge clk);
        end
        // Non-destination ready must not release the held token.
        out_r = 8'hFE;
        #1;
        tests++; if (in_r !== 1'b0) begin fails++; $display("FAIL bp_other_ready got=%b exp=0", in_r); end
        out_r = 8'h01;
        #1;
        tests++; if (in_r !== 1'b1) begin fails++; $display("FAIL bp_release_in_r got=%b exp=1", in_r); end
        @(negedge clk);
        tests++; if (out_v !== 8'h01) begin fails++; $display("FAIL bp_reload_out_v got=%h exp=01", out_v); end
        tests++; if (out_d !== 16'd1) begin fails++; $display("FAIL bp_reload_out_d got=%0d exp=1", out_d); end
        tests++; if (blk_idx !== 7'd2) begin fails++; $display("FAIL bp_reload_blk_idx got=%0d exp=2", blk_idx); end
        in_v = 1'b0; out_r = 8'hFF;
        @(negedge clk);
    endtask

    task automatic test_partial_burst();
        logic [3:0] exp_v;
        int ch;
        do_reset();
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k > 0) begin
                ch = (k - 1 < 10) ? (k - 1) / 3 : 0;
                exp_v = 4'd1 << ch;
                tests++; if (d2_out_d !== 16'(k - 1)) begin fails++; $display("FAIL pb_out_d k=%0d got=%0d exp=%0d", k - 1, d2_out_d, k - 1); end
                tests++; if (d2_out_v !== exp_v) begin fails++; $display("FAIL pb_out_v k=%0d got=%h exp=%h", k - 1, d2_out_v, exp_v); end
            end
            if (k <= 10) begin
                tests++; if (d2_blk_idx !== 4'(k % 10)) begin fails++; $display("FAIL pb_blk_idx k=%0d got=%0d exp=%0d", k, d2_blk_idx, k % 10); end
            end
            if (k <= 10) begin d2_in_d = 16'(k); d2_in_v = 1'b1; end
            else d2_in_v = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            in_d = 16'(k); in_v = 1'b1;
        end
        @(negedge clk);
        in_v = 1'b0;
        tests++; if (blk_idx !== 7'd37) begin fails++; $display("FAIL mr_pre_idx got=%0d exp=37", blk_idx); end
        tests++; if (out_v !== 8'h04) begin fails++; $display("FAIL mr_pre_out_v got=%h exp=04", out_v); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out_v !== 8'h00) begin fails++; $display("FAIL mr_out_v got=%h exp=00", out_v); end
        tests++; if (in_r !== 1'b1) begin fails++; $display("FAIL mr_in_r got=%b exp=1", in_r); end
        tests++; if (blk_idx !== 7'd0) begin fails++; $display("FAIL mr_blk_idx got=%0d exp=0", blk_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (blk_idx !== 7'd0) begin fails++; $display("FAIL mr_idx_at_accept got=%0d exp=0", blk_idx); end
        in_d = 16'd99; in_v = 1'b1;
        @(negedge clk);
        in_v = 1'b0;
        tests++; if (out_v !== 8'h01) begin fails++; $display("FAIL mr_next_out_v got=%h exp=01", out_v); end
        tests++; if (out_d !== 16'd99) begin fails++; $display("FAIL mr_next_out_d got=%0d exp=99", out_d); end
        @(negedge clk);
    endtask

`ifdef IZZ_EOB_FLAG_EN
    task automatic test_eob();
        do_reset();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k > 0) begin
                tests++; if (eob !== 1'b0) begin fails++; $display("FAIL eob_low k=%0d got=%b exp=0", k - 1, eob); end
            end
            in_d = 16'(k); in_v = 1'b1;
        end
        @(negedge clk);
        in_v = 1'b0; out_r = 8'h7F;
        for (int c = 0; c < 4; c++) begin
            tests++; if (eob !== 1'b1) begin fails++; $display("FAIL eob_high c=%0d got=%b exp=1", c, eob); end
            tests++; if (out_v !== 8'h80) begin fails++; $display("FAIL eob_out_v c=%0d got=%h exp=80", c, out_v); end
            if (c < 3) @(negedge clk);
        end
        out_r = 8'hFF;
        @(negedge clk);
        tests++; if (eob !== 1'b0) begin fails++; $display("FAIL eob_clear got=%b exp=0", eob); end
        tests++; if (out_v !== 8'h00) begin fails++; $display("FAIL eob_drain got=%h exp=00", out_v); end
    endtask
`endif

    task automatic test_random();
        logic [15:0] q_d[$];
        int          q_ch[$];
        int m_idx = 0, m_ch = 0, m_burst = 0;
        int sent = 0, popped = 0, cyc = 0;
        logic pop, exp_in_r;
        logic [7:0] exp_v;
        do_reset();
        while (popped < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_r = 8'($urandom);
            in_v  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_d  = 16'($urandom);
            #1;
            tests++; if (!$onehot0(out_v)) begin fails++; $display("FAIL rnd_onehot cyc=%0d got=%h", cyc, out_v); end
            pop = (out_v & out_r) != 8'h00;
            exp_in_r = (out_v == 8'h00) || pop;
            tests++; if (in_r !== exp_in_r) begin fails++; $display("FAIL rnd_in_r cyc=%0d got=%b exp=%b", cyc, in_r, exp_in_r); end
            if (pop) begin
                if (q_d.size() == 0) begin
                    tests++; fails++; $display("FAIL rnd_dup cyc=%0d got=%h exp=none", cyc, out_d);
                end else begin
                    exp_v = 8'd1 << q_ch.pop_front();
                    tests++; if (out_d !== q_d[0]) begin fails++; $display("FAIL rnd_data n=%0d got=%h exp=%h", popped, out_d, q_d[0]); end
                    tests++; if (out_v !== exp_v) begin fails++; $display("FAIL rnd_chan n=%0d got=%h exp=%h", popped, out_v, exp_v); end
                    void'(q_d.pop_front());
                end
                popped++;
            end
            if (in_v && in_r) begin
                tests++; if (blk_idx !== 7'(m_idx)) begin fails++; $display("FAIL rnd_blk_idx n=%0d got=%0d exp=%0d", sent, blk_idx, m_idx); end
                q_d.push_back(in_d);
                q_ch.push_back(m_ch);
                if (m_idx == 63) begin
                    m_idx = 0; m_ch = 0; m_burst = 0;
                end else begin
                    m_idx++;
                    if (m_burst == 1) begin m_burst = 0; m_ch = (m_ch == 7) ? 0 : m_ch + 1; end
                    else m_burst++;
                end
                sent++;
            end
        end
        in_v = 1'b0; out_r = 8'hFF;
        tests++; if (popped != 1000) begin fails++; $display("FAIL rnd_count got=%0d exp=1000", popped); end
        tests++; if (q_d.size() != 0) begin fails++; $display("FAIL rnd_leftover got=%0d exp=0", q_d.size()); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_partial_burst();
        test_mid_reset();
`ifdef IZZ_EOB_FLAG_EN
        test_eob();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
